// File: rtl/tcm4671_pkg.sv
// Shared widths, FSM state encoding and timeout read pattern for the TCM4671 register-access arbiter.
package tcm4671_pkg;

  localparam int TCM_ADDR_W = 7;
  localparam int TCM_DATA_W = 32;

  // Returned as read data when the engine never answers.
  localparam logic [TCM_DATA_W-1:0] TCM_TIMEOUT_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } tcm_state_e;

endpackage

// File: rtl/tcm4671_rr_picker.sv
// Combinational round-robin winner: the first requester at or after (i_last+1) mod NREQ, wrapping.
// Zero latency; o_vld is low when no request is pending.
module tcm4671_rr_picker #(
  parameter int NREQ = 3
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [2:0]      i_last,
  output logic            o_vld,
  output logic [2:0]      o_idx
);

  logic [3:0]      w_cand;
  logic [NREQ-1:0] w_onehot;

  // Scan from the farthest offset down so the nearest offset is written last and wins.
  always_comb begin
    o_vld    = 1'b0;
    o_idx    = i_last;
    w_cand   = '0;
    w_onehot = '0;
    for (int k = NREQ; k >= 1; k--) begin
      w_cand   = ({1'b0, i_last} + 4'(k)) % 4'(NREQ);
      w_onehot = {{(NREQ-1){1'b0}}, 1'b1} << w_cand;
      if (|(i_req & w_onehot)) begin
        o_vld = 1'b1;
        o_idx = w_cand[2:0];
      end
    end
  end

endmodule

// File: rtl/tcm4671_arbiter.sv
// Round-robin arbiter sharing one TCM4671 SPI engine: grant -> transmit next cycle, done -> ack next cycle.
// Requesters hold req until ack; `define TCM4671_ARB_TIMEOUT_EN adds a WAIT watchdog that acks with err=1.
module tcm4671_arbiter
  import tcm4671_pkg::*;
#(
  parameter int NREQ           = 3,
  parameter int TIMEOUT_CYCLES = 100_000
) (
  input  logic                            i_clk,
  input  logic                            i_reset,
  input  logic [NREQ-1:0]                 i_req,
  input  logic [NREQ-1:0][TCM_ADDR_W-1:0] i_req_addr,
  input  logic [NREQ-1:0]                 i_req_wr,
  input  logic [NREQ-1:0][TCM_DATA_W-1:0] i_req_wdata,
  output logic [NREQ-1:0]                 o_ack,
  output logic [TCM_DATA_W-1:0]           o_rdata,
  output logic                            o_err,
  output logic                            o_busy,
  output logic [2:0]                      o_gnt_id,
  output logic                            o_transmit,
  output logic [TCM_ADDR_W-1:0]           o_addr,
  output logic                            o_writeNOTread,
  output logic [TCM_DATA_W-1:0]           o_data_in,
  input  logic [TCM_DATA_W-1:0]           i_data_out,
  input  logic                            i_done
);

  tcm_state_e              r_state;
  logic [2:0]              r_gnt_id;
  logic [TCM_ADDR_W-1:0]   r_addr;
  logic                    r_wr;
  logic [TCM_DATA_W-1:0]   r_wdata;
  logic [TCM_DATA_W-1:0]   r_rdata;

  logic                    w_pick_vld;
  logic [2:0]              w_pick_idx;
  logic                    w_grant;
  logic                    w_tmo;

  logic [NREQ:0][TCM_ADDR_W-1:0] w_addr_chain;
  logic [NREQ:0]                 w_wr_chain;
  logic [NREQ:0][TCM_DATA_W-1:0] w_wdata_chain;

  tcm4671_rr_picker #(
    .NREQ (NREQ)
  ) u_picker (
    .i_req  (i_req),
    .i_last (r_gnt_id),
    .o_vld  (w_pick_vld),
    .o_idx  (w_pick_idx)
  );

  assign w_grant = (r_state == ST_IDLE) && w_pick_vld;

  // AND-OR mux of the winner's request fields.
  assign w_addr_chain[0]  = '0;
  assign w_wr_chain[0]    = 1'b0;
  assign w_wdata_chain[0] = '0;
  for (genvar g = 0; g < NREQ; g++) begin : g_sel
    logic w_hit;
    assign w_hit              = (w_pick_idx == 3'(g));
    assign w_addr_chain[g+1]  = w_addr_chain[g]  | ({TCM_ADDR_W{w_hit}} & i_req_addr[g]);
    assign w_wr_chain[g+1]    = w_wr_chain[g]    | (w_hit & i_req_wr[g]);
    assign w_wdata_chain[g+1] = w_wdata_chain[g] | ({TCM_DATA_W{w_hit}} & i_req_wdata[g]);
  end

`ifdef TCM4671_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  assign w_tmo = (r_state == ST_WAIT) && !i_done && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Counter is zeroed in ISSUE so it reads 0 in the first WAIT cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (r_state == ST_ISSUE) begin
        r_cnt <= '0;
      end else if (r_state == ST_WAIT) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_grant) begin
        r_err <= 1'b0;
      end else if (w_tmo) begin
        r_err <= 1'b1;
      end
    end
  end

  assign o_err = r_err;
`else
  assign w_tmo = 1'b0;
  assign o_err = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= ST_IDLE;
      r_gnt_id <= 3'(NREQ - 1);
      r_addr   <= '0;
      r_wr     <= 1'b0;
      r_wdata  <= '0;
      r_rdata  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pick_vld) begin
            r_gnt_id <= w_pick_idx;
            r_addr   <= w_addr_chain[NREQ];
            r_wr     <= w_wr_chain[NREQ];
            r_wdata  <= w_wdata_chain[NREQ];
            r_state  <= ST_ISSUE;
          end
        end
        ST_ISSUE: r_state <= ST_WAIT;
        ST_WAIT: begin
          if (i_done) begin
            if (!r_wr) begin
              r_rdata <= i_data_out;
            end
            r_state <= ST_ACK;
          end else if (w_tmo) begin
            r_rdata <= TCM_TIMEOUT_DATA;
            r_state <= ST_ACK;
          end
        end
        ST_ACK:  r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    o_ack = '0;
    if (r_state == ST_ACK) begin
      o_ack = {{(NREQ-1){1'b0}}, 1'b1} << r_gnt_id;
    end
  end

  assign o_busy         = (r_state != ST_IDLE);
  assign o_transmit     = (r_state == ST_ISSUE);
  assign o_gnt_id       = r_gnt_id;
  assign o_rdata        = r_rdata;
  assign o_addr         = r_addr;
  assign o_writeNOTread = r_wr;
  assign o_data_in      = r_wdata;

endmodule

// File: tb/tb_tcm4671_arbiter.sv
// Directed bench for tcm4671_arbiter: vector table of arbitration rounds plus reset, stray-done and timeout sequences.
module tb_tcm4671_arbiter;

  logic             clk = 1'b0;
  logic             reset;
  logic [2:0]       req;
  logic [2:0][6:0]  req_addr;
  logic [2:0]       req_wr;
  logic [2:0][31:0] req_wdata;
  logic [31:0]      data_out;
  logic             done;

  logic [2:0]       ack;
  logic [31:0]      rdata;
  logic             err;
  logic             busy;
  logic [2:0]       gnt_id;
  logic             transmit;
  logic [6:0]       addr;
  logic             wnr;
  logic [31:0]      data_in;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tcm4671_arbiter #(
    .NREQ           (3),
    .TIMEOUT_CYCLES (50)
  ) dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_req          (req),
    .i_req_addr     (req_addr),
    .i_req_wr       (req_wr),
    .i_req_wdata    (req_wdata),
    .o_ack          (ack),
    .o_rdata        (rdata),
    .o_err          (err),
    .o_busy         (busy),
    .o_gnt_id       (gnt_id),
    .o_transmit     (transmit),
    .o_addr         (addr),
    .o_writeNOTread (wnr),
    .o_data_in      (data_in),
    .i_data_out     (data_out),
    .i_done         (done)
  );

  typedef struct {
    logic [2:0]  req;
    logic        wr;
    logic [6:0]  addr;
    logic [31:0] wdata;
    logic [31:0] eng;
    int          dly;
    logic [2:0]  gnt;
    logic [31:0] exp_rdata;
    int          exp_wait;
    logic        drop;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Winner gets the vector's fields; the others get decoys so a wrong mux select shows up.
  task automatic drive_fields(input vec_t v);
    for (int r = 0; r < 3; r++) begin
      if (v.gnt == 3'(r)) begin
        req_addr[r]  = v.addr;
        req_wr[r]    = v.wr;
        req_wdata[r] = v.wdata;
      end else begin
        req_addr[r]  = 7'h7F;
        req_wr[r]    = ~v.wr;
        req_wdata[r] = ~v.wdata;
      end
    end
  endtask

  task automatic wait_transmit(input string tag, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!transmit && n < 12);
    if (!transmit) begin
      total++;
      bad++;
      $display("FAIL %s no transmit within %0d cycles", tag, n);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int n;
    drive_fields(v);
    req = v.req;
    wait_transmit(tag, n);
    chk({tag, " wait"}, 32'(n), 32'(v.exp_wait));
    chk({tag, " gnt"}, 32'(gnt_id), 32'(v.gnt));
    chk({tag, " addr"}, 32'(addr), 32'(v.addr));
    chk({tag, " wnr"}, 32'(wnr), 32'(v.wr));
    chk({tag, " data_in"}, data_in, v.wdata);
    chk({tag, " busy"}, 32'(busy), 32'd1);
    if (v.drop) req = 3'b000;
    // Fields changed after grant must not reach the engine.
    req_addr[v.gnt]  = ~v.addr;
    req_wr[v.gnt]    = ~v.wr;
    req_wdata[v.gnt] = ~v.wdata;
    step();
    chk({tag, " tx1"}, 32'(transmit), 32'd0);
    repeat (v.dly) step();
    done     = 1'b1;
    data_out = v.eng;
    step();
    done     = 1'b0;
    data_out = 32'h0BAD_0BAD;
    chk({tag, " ack"}, 32'(ack), 32'(3'b001 << v.gnt));
    chk({tag, " rdata"}, rdata, v.exp_rdata);
    chk({tag, " err"}, 32'(err), 32'd0);
    chk({tag, " addr hold"}, 32'(addr), 32'(v.addr));
    chk({tag, " data hold"}, data_in, v.wdata);
  endtask

  initial begin
    int n;
    vec_t vx;

    //            req     wr    addr   wdata          eng            dly gnt   rdata          wait drop
    vecs[0] = '{3'b111, 1'b0, 7'h01, 32'h0000_0000, 32'h1234_5678, 0, 3'd0, 32'h1234_5678, 1, 1'b0};
    vecs[1] = '{3'b111, 1'b0, 7'h10, 32'h0000_0000, 32'h0000_00A1, 1, 3'd1, 32'h0000_00A1, 2, 1'b0};
    vecs[2] = '{3'b111, 1'b0, 7'h11, 32'h0000_0000, 32'h0000_00A2, 2, 3'd2, 32'h0000_00A2, 2, 1'b0};
    vecs[3] = '{3'b111, 1'b0, 7'h12, 32'h0000_0000, 32'h0000_00A3, 0, 3'd0, 32'h0000_00A3, 2, 1'b0};
    vecs[4] = '{3'b100, 1'b1, 7'h02, 32'hCAFE_0001, 32'h5555_5555, 1, 3'd2, 32'h0000_00A3, 2, 1'b0};
    vecs[5] = '{3'b100, 1'b0, 7'h05, 32'h0000_0000, 32'h0000_0077, 0, 3'd2, 32'h0000_0077, 2, 1'b0};
    vecs[6] = '{3'b011, 1'b0, 7'h06, 32'h0000_0000, 32'h0000_0088, 3, 3'd0, 32'h0000_0088, 2, 1'b0};
    vecs[7] = '{3'b010, 1'b1, 7'h07, 32'h0000_1234, 32'h0000_0099, 0, 3'd1, 32'h0000_0088, 2, 1'b0};
    vecs[8] = '{3'b101, 1'b0, 7'h08, 32'h0000_0000, 32'h0000_00AA, 1, 3'd2, 32'h0000_00AA, 2, 1'b0};

    reset     = 1'b1;
    req       = '0;
    req_addr  = '0;
    req_wr    = '0;
    req_wdata = '0;
    data_out  = '0;
    done      = 1'b0;
    repeat (3) step();

    chk("rst ack", 32'(ack), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst transmit", 32'(transmit), 32'd0);
    chk("rst err", 32'(err), 32'd0);
    chk("rst rdata", rdata, 32'd0);
    chk("rst addr", 32'(addr), 32'd0);
    chk("rst wnr", 32'(wnr), 32'd0);
    chk("rst data_in", data_in, 32'd0);
    chk("rst gnt_id", 32'(gnt_id), 32'd2);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset while waiting on the engine.
    req = 3'b000;
    step();
    vx = '{3'b010, 1'b0, 7'h20, 32'h0, 32'h0, 0, 3'd1, 32'h0, 0, 1'b0};
    drive_fields(vx);
    req = 3'b010;
    wait_transmit("midrst", n);
    chk("midrst gnt", 32'(gnt_id), 32'd1);
    step();
    chk("midrst busy wait", 32'(busy), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    req   = 3'b000;
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst ack", 32'(ack), 32'd0);
    chk("midrst gnt_id", 32'(gnt_id), 32'd2);
    chk("midrst rdata", rdata, 32'd0);
    done = 1'b1;
    step();
    done = 1'b0;
    chk("midrst stray ack", 32'(ack), 32'd0);
    chk("midrst stray busy", 32'(busy), 32'd0);
    vx = '{3'b011, 1'b0, 7'h21, 32'h0, 32'h0000_00B0, 1, 3'd0, 32'h0000_00B0, 1, 1'b0};
    run_vec(vx, "postrst");

    // Requester drops req during the transaction; then a done arrives while idle.
    vx = '{3'b010, 1'b0, 7'h30, 32'h0, 32'h0000_00C0, 2, 3'd1, 32'h0000_00C0, 2, 1'b1};
    run_vec(vx, "drop");
    step();
    chk("drop ack 1cyc", 32'(ack), 32'd0);
    chk("drop idle busy", 32'(busy), 32'd0);
    done     = 1'b1;
    data_out = 32'hFFFF_0000;
    step();
    done     = 1'b0;
    chk("stray ack", 32'(ack), 32'd0);
    chk("stray busy", 32'(busy), 32'd0);
    step();
    chk("stray ack2", 32'(ack), 32'd0);
    chk("stray rdata", rdata, 32'h0000_00C0);

`ifdef TCM4671_ARB_TIMEOUT_EN
    vx = '{3'b001, 1'b0, 7'h40, 32'h0, 32'h0, 0, 3'd0, 32'h0, 0, 1'b0};
    drive_fields(vx);
    req = 3'b001;
    wait_transmit("tmo", n);
    req = 3'b000;
    step();
    n = 0;
    while (ack == 3'b000 && n < 200) begin
      step();
      n++;
    end
    chk("tmo cycles", 32'(n), 32'd50);
    chk("tmo ack", 32'(ack), 32'b001);
    chk("tmo err", 32'(err), 32'd1);
    chk("tmo rdata", rdata, 32'hDEAD_BEEF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/tcm4671_arbiter.md
TCM4671_ARBITER -- requirements
Module: tcm4671_arbiter

Interface
REQ-001 Parameter NREQ, default 3: number of requester ports (2..8).
REQ-002 Parameter TIMEOUT_CYCLES, default 100_000: watchdog limit in clk cycles (used only with TCM4671_ARB_TIMEOUT_EN).
REQ-003 clk  in  1  single system clock; all logic on posedge clk.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 req  in  NREQ  per-requester transaction request, level, held until ack.
REQ-006 req_addr  in  NREQ x 7  per-requester TCM4671 register address.
REQ-007 req_wr  in  NREQ  per-requester direction, 1 = write, 0 = read.
REQ-008 req_wdata  in  NREQ x 32  per-requester write data.
REQ-009 ack  out  NREQ  one-cycle completion pulse to the granted requester.
REQ-010 rdata  out  32  read result, shared, valid in the ack cycle.
REQ-011 err  out  1  timeout flag, valid in the ack cycle.
REQ-012 busy  out  1  high from grant until the ack cycle inclusive.
REQ-013 gnt_id  out  3  index of the current or last granted requester.
REQ-014 transmit  out  1  one-cycle start pulse to the SPI engine.
REQ-015 addr  out  7; writeNOTread  out  1; data_in  out  32  transaction fields to the engine, stable from transmit until done.
REQ-016 data_out  in  32  engine read data; done  in  1  engine one-cycle completion pulse.

Function
REQ-017 FSM states IDLE, ISSUE, WAIT, ACK; encoding is free.
REQ-018 IDLE: with any req bit high, select the winner round-robin starting at (gnt_id+1) mod NREQ, latch its addr/wr/wdata into addr/writeNOTread/data_in, set gnt_id, go to ISSUE; with no req, stay.
REQ-019 ISSUE: assert transmit for exactly one cycle, go to WAIT.
REQ-020 WAIT: on done, capture data_out into rdata (reads only; writes leave rdata unchanged), go to ACK.
REQ-021 ACK: pulse ack[gnt_id] for one cycle, return to IDLE.
REQ-022 Minimum request-to-ack latency is 3 cycles plus engine time; a requester sampled in IDLE cycle T sees transmit in T+1.
REQ-023 Back-to-back arbitration: with a req still high in the cycle after ACK, the next grant happens in that IDLE cycle; there is no extra idle cycle.
REQ-024 A single active requester is granted repeatedly without starvation; with all requesters active, each is served once per NREQ grants.
REQ-025 Request fields are sampled only at grant; later changes are ignored until ack.
REQ-026 A req dropped mid-transaction does not abort: the transaction completes and the ack pulse still occurs.
REQ-027 done outside WAIT is ignored.
REQ-028 busy = (state != IDLE).

Reset
REQ-029 reset forces IDLE in the next cycle, including mid-transaction; the engine is reset by its own reset.
REQ-030 Reset values: transmit 0, ack 0, err 0, busy 0, rdata 0, addr 0, writeNOTread 0, data_in 0, gnt_id NREQ-1 so requester 0 wins first.

Configuration
REQ-031 With TCM4671_ARB_TIMEOUT_EN defined: a counter clears on entry to WAIT; if done has not arrived after TIMEOUT_CYCLES cycles, go to ACK with err=1 and rdata=32'hDEAD_BEEF.
REQ-032 Without TCM4671_ARB_TIMEOUT_EN: no counter is built, err is tied to 0, and WAIT lasts indefinitely.

Structure
REQ-033 Package tcm4671_pkg holds TCM_ADDR_W=7, TCM_DATA_W=32, the FSM state enum and the TCM_TIMEOUT_DATA constant.
REQ-034 Sub-module tcm4671_rr_picker: combinational round-robin winner from req and the last grant, giving a valid flag and an index.

Verification
REQ-035 After reset, req=3'b001 read addr 7'h01, engine returns 32'h1234_5678 -> transmit one cycle after grant, addr=7'h01, writeNOTread=0, ack[0] pulse with rdata=32'h1234_5678.
REQ-036 req=3'b111 held, four transactions -> grant order 0,1,2,0 with no IDLE gap between ACK and the next grant.
REQ-037 Write from requester 2, addr 7'h02, wdata 32'hCAFE_0001 -> data_in=32'hCAFE_0001, writeNOTread=1, rdata unchanged at ack.
REQ-038 reset asserted in WAIT -> next cycle IDLE, busy=0, no ack; a new req is then granted normally to requester 0.
REQ-039 With TCM4671_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=50, done never asserted -> ack 50 cycles after WAIT entry with err=1 and rdata=32'hDEAD_BEEF.
REQ-040 Requester 1 drops req during WAIT, and done arrives while the FSM is in IDLE -> transaction completes with an ack[1] pulse, and the stray done causes no ack.
